double_div_sequencer: RTL and testbench

DOUBLE_DIV_SEQUENCER -- requirements
Module: double_div_sequencer

---
 rtl/double_div_pkg.sv | 21 ++
 rtl/double_div_result_fifo.sv | 58 +++++
 rtl/double_div_sequencer.sv | 118 +++++++++++
 tb/tb_double_div_sequencer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/double_div_pkg.sv
// Shared types and defaults for the double-precision divide sequencer.
package double_div_pkg;

  localparam int unsigned LATENCY_DEF    = 24;
  localparam int unsigned FIFO_DEPTH_DEF = 32;
  localparam int unsigned TAG_W          = 1;
  localparam int unsigned DATA_W         = 64;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } res_entry_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } inflight_t;

endpackage

// File: rtl/double_div_result_fifo.sv
// Synchronous result buffer; a write and a pop may coincide when full.
module double_div_result_fifo
  import double_div_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  res_entry_t    wdata_i,
  input  logic          pop_i,
  output res_entry_t    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  res_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/double_div_sequencer.sv
// Two-requester round-robin front end for a fixed-latency FP divider.
module double_div_sequencer
  import double_div_pkg::*;
#(
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [63:0] req0_dataa,
  input  logic [63:0] req0_datab,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_dataa,
  input  logic [63:0] req1_datab,
  output logic        req1_ready,
  output logic [63:0] div_dataa,
  output logic [63:0] div_datab,
  input  logic [63:0] div_result,
  output logic        res_valid,
  output logic        res_tag,
  output logic [63:0] res_data,
  input  logic        res_ready,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic          last_q, last_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [63:0]   opa_q, opa_d;
  logic [63:0]   opb_q, opb_d;
  inflight_t     pipe_q [LATENCY];

  logic          credit_ok, gnt0, gnt1, acc, pop;
  res_entry_t    head, wentry;
  logic          f_empty, f_full;
  logic [CW-1:0] f_count;
  logic          unused_fifo;

  // last_q holds the most recently granted requester index
  assign credit_ok  = credit_q < CW'(FIFO_DEPTH);
  assign gnt0       = req0_valid && (!req1_valid || last_q);
  assign gnt1       = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = !reset && credit_ok && gnt0;
  assign req1_ready = !reset && credit_ok && gnt1;
  assign acc        = req0_ready || req1_ready;

  assign res_valid  = !reset && !f_empty;
  assign res_tag    = head.tag;
  assign res_data   = head.data;
  assign pop        = res_valid && res_ready;
  assign busy       = !reset && (credit_q != '0);

  assign div_dataa  = opa_d;
  assign div_datab  = opb_d;

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    last_d   = last_q;
    credit_d = credit_q + CW'(acc) - CW'(pop);
    unique case (1'b1)
      reset: begin
        opa_d = '0;
        opb_d = '0;
      end
      req1_ready: begin
        opa_d  = req1_dataa;
        opb_d  = req1_datab;
        last_d = 1'b1;
      end
      req0_ready: begin
        opa_d  = req0_dataa;
        opb_d  = req0_datab;
        last_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q   <= 1'b1;
      credit_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      last_q    <= last_d;
      credit_q  <= credit_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      pipe_q[0] <= {acc, tag_t'(req1_ready)};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign wentry = {pipe_q[LATENCY-1].tag, div_result};

  double_div_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (pipe_q[LATENCY-1].valid),
    .wdata_i(wentry),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (f_full),
    .empty_o(f_empty),
    .count_o(f_count)
  );

  assign unused_fifo = f_full ^ (^f_count);

endmodule

// File: tb/tb_double_div_sequencer.sv
// Bench: delay-line divider model, scoreboard and scenario tasks.
module tb_double_div_sequencer;
  import double_div_pkg::*;

  localparam int L = 24;
  localparam int D = 32;
  localparam logic [63:0] DIV0_PAT = 64'h7FF8_DEAD_BEEF_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [63:0] req0_dataa = '0, req0_datab = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [63:0] req1_dataa = '0, req1_datab = '0;
  logic        req1_ready;
  logic [63:0] div_dataa, div_datab, div_result;
  logic        res_valid, res_tag;
  logic [63:0] res_data;
  logic        res_ready = 1'b0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  double_div_sequencer #(
    .LATENCY(L),
    .FIFO_DEPTH(D)
  ) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_dataa(req0_dataa),
    .req0_datab(req0_datab), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dataa(req1_dataa),
    .req1_datab(req1_datab), .req1_ready(req1_ready),
    .div_dataa(div_dataa), .div_datab(div_datab),
    .div_result(div_result),
    .res_valid(res_valid), .res_tag(res_tag),
    .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] fdiv(input logic [63:0] a,
                                       input logic [63:0] b);
    if (b[62:0] == 63'd0) return DIV0_PAT;
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rnd_op();
    return $realtobits(real'($urandom_range(1, 100000)) / 64.0);
  endfunction

  // External divider: result L cycles after operands
  logic [63:0] dpipe [L];
  always @(posedge clock) begin
    dpipe[0] <= fdiv(div_dataa, div_datab);
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result = dpipe[L-1];

  res_entry_t exp_q[$];
  res_entry_t got_q[$];
  int outstanding = 0;
  int max_out = 0;

  always @(negedge clock) begin
    if (reset) begin
      outstanding = 0;
    end else begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back(res_entry_t'({1'b0, fdiv(req0_dataa, req0_datab)}));
        outstanding++;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(res_entry_t'({1'b1, fdiv(req1_dataa, req1_datab)}));
        outstanding++;
      end
      if (res_valid && res_ready) begin
        got_q.push_back(res_entry_t'({res_tag, res_data}));
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    exp_q.delete();
    got_q.delete();
    max_out = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_dataa = rnd_op(); req0_datab = rnd_op();
    req1_valid = 1'b1; req1_dataa = rnd_op(); req1_datab = rnd_op();
    res_ready = 1'b1;
    cyc(); cyc();
    @(negedge clock);
    n_vec += 6;
    if (res_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_res_valid: got %b want 0", res_valid);
    end
    if (req0_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready);
    end
    if (req1_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (div_dataa !== 64'd0) begin
      n_err++; $display("FAIL rst_div_dataa: got %h want 0", div_dataa);
    end
    if (div_datab !== 64'd0) begin
      n_err++; $display("FAIL rst_div_datab: got %h want 0", div_datab);
    end
    do_reset();
    @(negedge clock);
    n_vec += 2;
    if (res_valid !== 1'b0) begin
      n_err++; $display("FAIL post_rst_res_valid: got %b want 0", res_valid);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL post_rst_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    cyc();
    req0_valid = 1'b1;
    req0_dataa = 64'h4018_0000_0000_0000;
    req0_datab = 64'h4000_0000_0000_0000;
    @(negedge clock);
    n_vec += 3;
    if (req0_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %b want 1", req0_ready);
    end
    if (req1_ready !== 1'b0) begin
      n_err++; $display("FAIL single_ready1: got %b want 0", req1_ready);
    end
    if (div_dataa !== 64'h4018_0000_0000_0000) begin
      n_err++; $display("FAIL single_div_dataa: got %h want 4018000000000000", div_dataa);
    end
    cyc();
    req0_valid = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) cyc();
      @(negedge clock);
      n_vec++;
      if (k == 1) begin
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL single_busy: got %b want 1", busy);
        end
      end else if (k < 25) begin
        if (res_valid !== 1'b0) begin
          n_err++; $display("FAIL single_early k=%0d: got %b want 0", k, res_valid);
        end
      end else if (k == 25) begin
        n_vec += 2;
        if (res_valid !== 1'b1) begin
          n_err++; $display("FAIL single_res_valid: got %b want 1", res_valid);
        end
        if (res_tag !== 1'b0) begin
          n_err++; $display("FAIL single_tag: got %b want 0", res_tag);
        end
        if (res_data !== 64'h4008_0000_0000_0000) begin
          n_err++; $display("FAIL single_data: got %h want 4008000000000000", res_data);
        end
      end else begin
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL single_idle_busy: got %b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_alternate();
    res_entry_t want [4];
    logic [63:0] a0, b0, a1, b1;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
      req0_valid = 1'b1; req0_dataa = a0; req0_datab = b0;
      req1_valid = 1'b1; req1_dataa = a1; req1_datab = b1;
      want[i] = (i % 2 == 1) ? res_entry_t'({1'b1, fdiv(a1, b1)})
                             : res_entry_t'({1'b0, fdiv(a0, b0)});
      @(negedge clock);
      n_vec++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL alt_grant i=%0d: got r1r0=%b%b want %0d", i,
                 req1_ready, req0_ready, i % 2);
      end
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (60) begin
      cyc();
      if (got_q.size() >= 4) break;
    end
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++; $display("FAIL alt_count: got %0d want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got_q[i] !== want[i]) begin
          n_err++;
          $display("FAIL alt_result i=%0d: got %h want %h", i, got_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic check_scoreboard(string name);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s_entry %0d: got %h want %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic drain(string name);
    bit done = 1'b0;
    idle_inputs();
    res_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cyc();
      @(negedge clock);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL %s_drain_timeout: busy got 1 want 0", name);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int extra = 0;
    do_reset();
    res_ready = 1'b0;
    for (int k = 0; k < 70; k++) begin
      cyc();
      req0_valid = 1'b1; req0_dataa = rnd_op(); req0_datab = rnd_op();
      @(negedge clock);
      if (req0_ready) acc++;
    end
    n_vec += 3;
    if (acc != D) begin
      n_err++; $display("FAIL bp_accepts: got %0d want %0d", acc, D);
    end
    if (req0_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_full: got %b want 0", req0_ready);
    end
    if (res_valid !== 1'b1 || res_data !== exp_q[0].data) begin
      n_err++;
      $display("FAIL bp_head: got v=%b %h want v=1 %h", res_valid, res_data, exp_q[0].data);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      res_ready = (k == 0);
      req0_dataa = rnd_op(); req0_datab = rnd_op();
      @(negedge clock);
      if (req0_ready) extra++;
    end
    n_vec++;
    if (extra != 1) begin
      n_err++; $display("FAIL bp_one_more: got %0d want 1", extra);
    end
  endtask

  task automatic test_full_stream();
    int acc = 0;
    res_ready = 1'b0;
    req0_valid = 1'b0;
    repeat (30) cyc();
    for (int k = 0; k < 100; k++) begin
      if (k > 0) cyc();
      res_ready = 1'b1;
      req1_valid = 1'b1; req1_dataa = rnd_op(); req1_datab = rnd_op();
      @(negedge clock);
      if (req1_ready) acc++;
    end
    n_vec++;
    if (acc != 99) begin
      n_err++; $display("FAIL full_stream_accepts: got %0d want 99", acc);
    end
    cyc();
    drain("full_stream");
    n_vec++;
    if (max_out > D) begin
      n_err++; $display("FAIL full_stream_credit: got %0d want <= %0d", max_out, D);
    end
    check_scoreboard("full_stream");
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    do_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      req0_valid = 1'b1; req0_dataa = rnd_op(); req0_datab = rnd_op();
    end
    cyc();
    req0_valid = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    cyc(); cyc();
    exp_q.delete();
    got_q.delete();
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_busy: got %b want 0", busy);
    end
    for (int k = 0; k < 2 * L; k++) begin
      cyc();
      @(negedge clock);
      if (res_valid) seen++;
    end
    n_vec += 2;
    if (seen != 0) begin
      n_err++; $display("FAIL flush_res_valid: got %0d cycles want 0", seen);
    end
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL flush_pops: got %0d want 0", got_q.size());
    end
  endtask

  task automatic test_div_zero();
    bit found = 1'b0;
    do_reset();
    res_ready = 1'b1;
    cyc();
    req1_valid = 1'b1;
    req1_dataa = 64'h3FF0_0000_0000_0000;
    req1_datab = 64'h0;
    @(negedge clock);
    n_vec++;
    if (req1_ready !== 1'b1) begin
      n_err++; $display("FAIL div0_ready: got %b want 1", req1_ready);
    end
    cyc();
    req1_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (res_valid) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    n_vec += 3;
    if (!found) begin
      n_err++; $display("FAIL div0_timeout: res_valid got 0 want 1");
    end
    if (res_tag !== 1'b1) begin
      n_err++; $display("FAIL div0_tag: got %b want 1", res_tag);
    end
    if (res_data !== DIV0_PAT) begin
      n_err++; $display("FAIL div0_data: got %h want %h", res_data, DIV0_PAT);
    end
    cyc();
  endtask

  task automatic test_random();
    int credit = 0;
    bit last_g = 1'b1;
    bit any_acc, pop;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cyc();
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      res_ready  = ($urandom_range(0, 3) == 0);
      req0_dataa = rnd_op(); req0_datab = rnd_op();
      req1_dataa = rnd_op(); req1_datab = rnd_op();
      @(negedge clock);
      any_acc = req0_ready || req1_ready;
      pop = res_valid && res_ready;
      n_vec++;
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid) ||
          (req0_ready && req1_ready)) begin
        n_err++;
        $display("FAIL rnd_ready_legal k=%0d: got r1r0=%b%b", k, req1_ready, req0_ready);
      end
      n_vec++;
      if (any_acc !== ((req0_valid || req1_valid) && credit < D)) begin
        n_err++;
        $display("FAIL rnd_accept k=%0d: got %b want %b", k, any_acc,
                 (req0_valid || req1_valid) && credit < D);
      end
      if (req0_valid && req1_valid && any_acc) begin
        n_vec++;
        if (req1_ready !== !last_g) begin
          n_err++; $display("FAIL rnd_rr k=%0d: got r1=%b want %b", k, req1_ready, !last_g);
        end
      end
      if (req0_ready) last_g = 1'b0;
      if (req1_ready) last_g = 1'b1;
      credit = credit + int'(any_acc) - int'(pop);
    end
    cyc();
    drain("random");
    check_scoreboard("random");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_full_stream();
    test_reset_flush();
    test_div_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
